// File: rtl/mpr121_pkg.sv
// Shared types and register map for the MPR121 target emulator.
package mpr121_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    localparam int unsigned REG_NUM = 128;

    localparam logic [7:0] REG_TOUCH_L = 8'h00;
    localparam logic [7:0] REG_TOUCH_H = 8'h01;
    localparam logic [7:0] REG_CDC_CFG = 8'h5C;
    localparam logic [7:0] REG_CDT_CFG = 8'h5D;
    localparam logic [7:0] REG_ECR     = 8'h5E;
    localparam logic [7:0] REG_SRST    = 8'h80;

    localparam logic [7:0] SRST_KEY    = 8'h63;
    localparam logic [7:0] CDC_CFG_RST = 8'h10;
    localparam logic [7:0] CDT_CFG_RST = 8'h24;

    // Power-on / soft-reset value of one register-file entry.
    function automatic logic [7:0] reg_reset_val(input logic [6:0] idx);
        logic [7:0] val;
        val = 8'h00;
        if ({1'b0, idx} == REG_CDC_CFG) val = CDC_CFG_RST;
        if ({1'b0, idx} == REG_CDT_CFG) val = CDT_CFG_RST;
        return val;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA and produces registered bus-event pulses.
module i2c_line_sync (
    input  logic clk_in,
    input  logic rst_in,
    input  logic scl_in,
    input  logic sda_in,
    input  logic sda_oe_mask_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;

    // Two-flop synchronizers, one history stage, registered edge/condition pulses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            sda_o      <= 1'b1;
            scl_rise_o <= 1'b0;
            scl_fall_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
            sda_o      <= sda_sync_q[1];
            scl_rise_o <= scl_sync_q[1] & ~scl_prev_q;
            scl_fall_o <= ~scl_sync_q[1] & scl_prev_q;
            // Our own SDA drive must never be mistaken for a START/STOP.
            start_o    <= scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1] & ~sda_oe_mask_i;
            stop_o     <= scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1] & ~sda_oe_mask_i;
        end
    end

endmodule

// File: rtl/mpr121_target_emulator.sv
// I2C target emulating the MPR121 register interface for loopback/simulation.
module mpr121_target_emulator
    import mpr121_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h5A,
    parameter int unsigned HOLD_CYC    = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe_out,
    input  logic [11:0] touch_in,
    output logic [7:0]  ecr_out,
    output logic        reg_wr_valid_out,
    output logic [7:0]  reg_wr_addr_out,
    output logic [7:0]  reg_wr_data_out,
    output logic        busy_out
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

    logic sda_s, scl_rise, scl_fall, start_p, stop_p;

    state_t            state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic [7:0]        rd_shift_q;
    logic [7:0]        ptr_q;
    logic              acked_q;
    logic              rw_q;
    logic [HOLD_W-1:0] hold_q;
    logic              pend_oe_q;
    logic [7:0]        regs_q [REG_NUM];

    logic [7:0] byte_c;
    logic [7:0] rd_byte_c;
    logic       wr_ok_c;

    i2c_line_sync u_sync (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .scl_in        (scl_in),
        .sda_in        (sda_in),
        .sda_oe_mask_i (sda_oe_out),
        .sda_o         (sda_s),
        .scl_rise_o    (scl_rise),
        .scl_fall_o    (scl_fall),
        .start_o       (start_p),
        .stop_o        (stop_p)
    );

    assign ecr_out   = regs_q[7'(REG_ECR)];
    assign byte_c    = {shift_q[6:0], sda_s};
    assign rd_byte_c = ptr_q[7] ? 8'h00 : regs_q[ptr_q[6:0]];
    // Writable window 0x02..0x7F; in run mode only ECR stays writable.
    assign wr_ok_c   = !ptr_q[7] && (ptr_q[6:1] != 6'd0) &&
                       ((ecr_out[5:0] == 6'd0) || (ptr_q == REG_ECR));

    // Bus protocol FSM, register file and delayed SDA drive.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q          <= ST_IDLE;
            bit_cnt_q        <= 3'd0;
            shift_q          <= 8'h00;
            rd_shift_q       <= 8'h00;
            ptr_q            <= 8'h00;
            acked_q          <= 1'b0;
            rw_q             <= 1'b0;
            hold_q           <= HOLD_W'(0);
            pend_oe_q        <= 1'b0;
            sda_oe_out       <= 1'b0;
            busy_out         <= 1'b0;
            reg_wr_valid_out <= 1'b0;
            reg_wr_addr_out  <= 8'h00;
            reg_wr_data_out  <= 8'h00;
            for (int unsigned i = 0; i < REG_NUM; i++) regs_q[i] <= reg_reset_val(7'(i));
        end else begin
            reg_wr_valid_out <= 1'b0;
            if (hold_q != HOLD_W'(0)) begin
                hold_q <= hold_q - HOLD_W'(1);
                if (hold_q == HOLD_W'(1)) sda_oe_out <= pend_oe_q;
            end

            if (start_p) begin
                state_q    <= ST_ADDR;
                bit_cnt_q  <= 3'd0;
                acked_q    <= 1'b0;
                busy_out   <= 1'b0;
                hold_q     <= HOLD_W'(0);
                sda_oe_out <= 1'b0;
            end else if (stop_p) begin
                state_q    <= ST_IDLE;
                acked_q    <= 1'b0;
                busy_out   <= 1'b0;
                hold_q     <= HOLD_W'(0);
                sda_oe_out <= 1'b0;
            end else if (scl_rise) begin
                case (state_q)
                    ST_ADDR, ST_PTR, ST_WR_DATA: begin
                        shift_q   <= byte_c;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            acked_q <= 1'b0;
                            if (state_q == ST_ADDR) begin
                                if (byte_c[7:1] == TARGET_ADDR) begin
                                    state_q  <= ST_ADDR_ACK;
                                    busy_out <= 1'b1;
                                    rw_q     <= byte_c[0];
                                    if (byte_c[0]) begin
                                        regs_q[7'(REG_TOUCH_L)] <= touch_in[7:0];
                                        regs_q[7'(REG_TOUCH_H)] <= {4'h0, touch_in[11:8]};
                                    end
                                end else begin
                                    state_q <= ST_IGNORE;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_q   <= byte_c;
                                state_q <= ST_PTR_ACK;
                            end else begin
                                state_q <= ST_WR_ACK;
                                if (ptr_q == REG_SRST && byte_c == SRST_KEY) begin
                                    ptr_q <= 8'h00;
                                    for (int unsigned i = 0; i < REG_NUM; i++)
                                        regs_q[i] <= reg_reset_val(7'(i));
                                end else begin
                                    ptr_q <= ptr_q + 8'd1;
                                    if (wr_ok_c) begin
                                        regs_q[ptr_q[6:0]] <= byte_c;
                                        reg_wr_valid_out   <= 1'b1;
                                        reg_wr_addr_out    <= ptr_q;
                                        reg_wr_data_out    <= byte_c;
                                    end
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: acked_q <= 1'b1;
                    ST_RD_DATA: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_RD_ACK;
                            acked_q <= 1'b0;
                        end
                    end
                    ST_RD_ACK: begin
                        if (!sda_s) begin
                            ptr_q   <= ptr_q + 8'd1;
                            acked_q <= 1'b1;
                        end else begin
                            state_q  <= ST_IGNORE;
                            busy_out <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state_q)
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                        hold_q <= HOLD_W'(HOLD_CYC);
                        if (!acked_q) begin
                            pend_oe_q <= 1'b1;
                        end else begin
                            acked_q   <= 1'b0;
                            bit_cnt_q <= 3'd0;
                            pend_oe_q <= 1'b0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_q    <= ST_RD_DATA;
                                pend_oe_q  <= ~rd_byte_c[7];
                                rd_shift_q <= {rd_byte_c[6:0], 1'b0};
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_q <= ST_PTR;
                            end else begin
                                state_q <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        hold_q     <= HOLD_W'(HOLD_CYC);
                        pend_oe_q  <= ~rd_shift_q[7];
                        rd_shift_q <= {rd_shift_q[6:0], 1'b0};
                    end
                    ST_RD_ACK: begin
                        hold_q <= HOLD_W'(HOLD_CYC);
                        if (!acked_q) begin
                            pend_oe_q <= 1'b0;
                        end else begin
                            state_q    <= ST_RD_DATA;
                            acked_q    <= 1'b0;
                            bit_cnt_q  <= 3'd0;
                            pend_oe_q  <= ~rd_byte_c[7];
                            rd_shift_q <= {rd_byte_c[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mpr121_target_emulator.sv
// Directed bench: bit-banged I2C initiator against the MPR121 target emulator.
module tb_mpr121_target_emulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_scl = 1'b1;
    logic        m_sda_low = 1'b0;
    logic        sda_line;
    logic        sda_oe;
    logic [11:0] touch = 12'h000;
    logic [7:0]  ecr;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    logic [7:0] last_wr_addr = 8'h00;
    logic [7:0] last_wr_data = 8'h00;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;

    assign sda_line = ~(m_sda_low | sda_oe);

    always #5 clk = ~clk;

    mpr121_target_emulator #(.TARGET_ADDR(7'h5A), .HOLD_CYC(4)) dut (
        .clk_in           (clk),
        .rst_in           (rst_n),
        .scl_in           (m_scl),
        .sda_in           (sda_line),
        .sda_oe_out       (sda_oe),
        .touch_in         (touch),
        .ecr_out          (ecr),
        .reg_wr_valid_out (wr_valid),
        .reg_wr_addr_out  (wr_addr),
        .reg_wr_data_out  (wr_data),
        .busy_out         (busy)
    );

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
        end
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic q();
        repeat (10) @(negedge clk);
    endtask

    task automatic bit_x(input logic b, output logic r);
        m_sda_low = ~b;
        q();
        m_scl = 1'b1;
        q();
        r = sda_line;
        q();
        m_scl = 1'b0;
        q();
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        q();
        m_scl = 1'b1;
        q();
        m_sda_low = 1'b1;
        q();
        m_scl = 1'b0;
        q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        q();
        m_scl = 1'b1;
        q();
        m_sda_low = 1'b0;
        q();
        q();
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(b[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            d[i] = r;
        end
        bit_x(~ack, r);
    endtask

    task automatic read_reg(input logic [7:0] ptr, output logic [7:0] d);
        logic a;
        i2c_start();
        wr_byte(8'hB4, a);
        wr_byte(ptr, a);
        i2c_start();
        wr_byte(8'hB5, a);
        rd_byte(1'b0, d);
        i2c_stop();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", sda_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ecr !== 8'h00) begin failures++; $display("FAIL reset_ecr got=%h exp=00", ecr); end
        checks++; if ({wr_valid, wr_addr, wr_data} !== 17'h0) begin failures++; $display("FAIL reset_wr got=%b/%h/%h exp=0/00/00", wr_valid, wr_addr, wr_data); end
        rst_n = 1'b1;
        q();
    endtask

    task automatic test_ecr_write();
        logic a0, a1, a2;
        i2c_start();
        wr_byte(8'hB4, a0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ecr_busy got=%b exp=1", busy); end
        wr_byte(8'h5E, a1);
        wr_byte(8'h0C, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL ecr_acks got=%b exp=111", {a0, a1, a2}); end
        checks++; if (ecr !== 8'h0C) begin failures++; $display("FAIL ecr_value got=%h exp=0c", ecr); end
        checks++; if (wr_cnt !== 1) begin failures++; $display("FAIL ecr_pulses got=%0d exp=1", wr_cnt); end
        checks++; if ({last_wr_addr, last_wr_data} !== 16'h5E0C) begin failures++; $display("FAIL ecr_wr_bus got=%h/%h exp=5e/0c", last_wr_addr, last_wr_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ecr_busy_stop got=%b exp=0", busy); end
    endtask

    task automatic test_run_mode_block();
        logic a0, a1, a2;
        logic [7:0] d;
        i2c_start();
        wr_byte(8'hB4, a0);
        wr_byte(8'h41, a1);
        wr_byte(8'h0F, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL run_acks got=%b exp=111", {a0, a1, a2}); end
        checks++; if (wr_cnt !== 1) begin failures++; $display("FAIL run_no_pulse got=%0d exp=1", wr_cnt); end
        read_reg(8'h41, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL run_readback got=%h exp=00", d); end
    endtask

    task automatic test_touch_read();
        logic a;
        logic [7:0] d0, d1;
        touch = 12'hA5C;
        i2c_start();
        wr_byte(8'hB4, a);
        wr_byte(8'h00, a);
        i2c_start();
        wr_byte(8'hB5, a);
        rd_byte(1'b1, d0);
        touch = 12'h3F1;
        rd_byte(1'b0, d1);
        i2c_stop();
        checks++; if (d0 !== 8'h5C) begin failures++; $display("FAIL touch_lo got=%h exp=5c", d0); end
        checks++; if (d1 !== 8'h0A) begin failures++; $display("FAIL touch_hi_coherent got=%h exp=0a", d1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL touch_busy got=%b exp=0", busy); end
    endtask

    task automatic test_other_addr();
        logic a0, a1;
        logic [7:0] d;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        wr_byte(8'hB6, a0);
        wr_byte(8'h5D, a1);
        i2c_stop();
        checks++; if (a0 !== 1'b0) begin failures++; $display("FAIL other_nack got=%b exp=0", a0); end
        checks++; if (oe_seen !== 1'b0) begin failures++; $display("FAIL other_oe got=%b exp=0", oe_seen); end
        checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL other_busy got=%b exp=0", busy_seen); end
        read_reg(8'h5D, d);
        checks++; if (d !== 8'h24) begin failures++; $display("FAIL other_then_5d got=%h exp=24", d); end
    endtask

    task automatic test_wrap_and_soft_reset();
        logic a;
        logic [7:0] d;
        int base;
        base = wr_cnt;
        i2c_start();
        wr_byte(8'hB4, a);
        wr_byte(8'hFF, a);
        wr_byte(8'h11, a);
        wr_byte(8'h22, a);
        i2c_stop();
        checks++; if (wr_cnt !== base) begin failures++; $display("FAIL wrap_no_pulse got=%0d exp=%0d", wr_cnt, base); end
        // Current-address read: pointer should sit at 0x01 after the wrap.
        i2c_start();
        wr_byte(8'hB5, a);
        rd_byte(1'b0, d);
        i2c_stop();
        checks++; if (d !== 8'h03) begin failures++; $display("FAIL wrap_ptr_read got=%h exp=03", d); end
        i2c_start();
        wr_byte(8'hB4, a);
        wr_byte(8'h80, a);
        wr_byte(8'h63, a);
        i2c_stop();
        checks++; if (ecr !== 8'h00) begin failures++; $display("FAIL srst_ecr got=%h exp=00", ecr); end
        read_reg(8'h5D, d);
        checks++; if (d !== 8'h24) begin failures++; $display("FAIL srst_5d got=%h exp=24", d); end
        read_reg(8'h5C, d);
        checks++; if (d !== 8'h10) begin failures++; $display("FAIL srst_5c got=%h exp=10", d); end
        base = wr_cnt;
        i2c_start();
        wr_byte(8'hB4, a);
        wr_byte(8'h41, a);
        wr_byte(8'h0F, a);
        i2c_stop();
        checks++; if (wr_cnt !== base + 1) begin failures++; $display("FAIL stop_mode_pulse got=%0d exp=%0d", wr_cnt, base + 1); end
        checks++; if ({last_wr_addr, last_wr_data} !== 16'h410F) begin failures++; $display("FAIL stop_mode_bus got=%h/%h exp=41/0f", last_wr_addr, last_wr_data); end
        read_reg(8'h41, d);
        checks++; if (d !== 8'h0F) begin failures++; $display("FAIL stop_mode_readback got=%h exp=0f", d); end
    endtask

    task automatic test_reset_mid_ack();
        logic r, a0, a1, a2;
        logic [7:0] b;
        int base;
        b = 8'hB4;
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_x(b[i], r);
        m_sda_low = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL mid_ack_driving got=%b exp=1", sda_oe); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL mid_ack_async_release got=%b exp=0", sda_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_ack_busy got=%b exp=0", busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q();
        i2c_stop();
        base = wr_cnt;
        i2c_start();
        wr_byte(8'hB4, a0);
        wr_byte(8'h5E, a1);
        wr_byte(8'h05, a2);
        i2c_stop();
        checks++; if ({a0, a1, a2} !== 3'b111) begin failures++; $display("FAIL post_reset_acks got=%b exp=111", {a0, a1, a2}); end
        checks++; if (ecr !== 8'h05) begin failures++; $display("FAIL post_reset_ecr got=%h exp=05", ecr); end
        checks++; if (wr_cnt !== base + 1) begin failures++; $display("FAIL post_reset_pulse got=%0d exp=%0d", wr_cnt, base + 1); end
    endtask

    initial begin
        test_reset();
        test_ecr_write();
        test_run_mode_block();
        test_touch_read();
        test_other_addr();
        test_wrap_and_soft_reset();
        test_reset_mid_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mpr121_target_emulator.md
Name: mpr121_target_emulator

Overview:
- I2C target (responder) that emulates an MPR121 capacitive touch sensor at the register level.
- It is the bus-side counterpart of the team's MPR121 initiator. It lets the initiator and its touch-readout FSM run in simulation and in FPGA-to-FPGA loopback without a physical sensor.
- Touch electrodes come from a 12-bit input vector. Configuration writes from the initiator are exposed as a write strobe.

Parameters:
- TARGET_ADDR, 7'h5A, 7-bit I2C address this instance ACKs.
- HOLD_CYC, 4, clk cycles after a detected SCL falling edge before SDA drive changes. Must be at least 1 and less than the SCL-low time in cycles.

Ports:
- clk_in, input, 1, system clock; must be at least 10x the SCL frequency.
- rst_in, input, 1, asynchronous, active-low reset.
- scl_in, input, 1, raw SCL from the bus (asynchronous).
- sda_in, input, 1, raw SDA from the bus (asynchronous).
- sda_oe_out, input direction n/a; this is an output, 1, 1 = pull SDA low; 0 = release. The top level ties the inout as sda = sda_oe_out ? 0 : 'z.
- touch_in, input, 12, live electrode touch state; bit i = electrode i.
- ecr_out, output, 8, current ECR register (0x5E) contents.
- reg_wr_valid_out, output, 1, one-cycle pulse per accepted register write.
- reg_wr_addr_out, output, 8, register address of that write.
- reg_wr_data_out, output, 8, data of that write.
- busy_out, output, 1, high from an address-matched START until STOP, NACK end, or START.

Behaviour:
- Reset (rst_in low, async): all outputs 0. State is IDLE, pointer is 0x00, and the register file is 0x00 except reg 0x5D = 0x24 and reg 0x5C = 0x10.
- Line conditioning: scl_in and sda_in each pass through 2-flop synchronizers. Edge detect runs on the synced values.
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - START/STOP detection is ignored while sda_oe_out = 1.
- Data sampling: SDA is sampled on the SCL rising edge. The target changes SDA drive exactly HOLD_CYC cycles after an SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- Global rules:
  - START from any state goes to ADDR and clears the bit counter.
  - STOP from any state goes to IDLE, releases SDA and drops busy_out.
  - START/STOP takes priority over bit processing in the same cycle.
- ADDR: shift 8 bits, MSB first.
  - If the upper 7 bits match TARGET_ADDR, go to ADDR_ACK and set busy_out.
  - Otherwise go to IGNORE. IGNORE never drives SDA and waits for START or STOP.
- ADDR_ACK: drive low from the falling edge after bit 8 until the next falling edge.
  - R/W = 0: go to PTR.
  - R/W = 1: go to RD_DATA. At this point, snapshot touch_in into regs 0x00 (bits 7:0) and 0x01 (bits 3:0, upper nibble 0), so a multi-byte read is coherent.
- PTR: the first written byte loads the pointer. Then PTR_ACK (always ACK), then WR_DATA.
- WR_DATA: after 8 bits, enter WR_ACK (always ACK), then handle the byte:
  - Write rule: ptr 0x00–0x01 are read-only (ignored, still ACKed).
  - ptr 0x02–0x7F: write, unless ECR[5:0] != 0 (run mode) and ptr != 0x5E; in that case ignore.
  - ptr 0x80 with data 0x63: soft reset of the register file and pointer to reset values, with no bus state change.
  - Other ptr 0x80 and above: ignore.
  - An accepted write pulses reg_wr_valid_out on the cycle after the 8th SCL rise, with addr/data outputs held until the next write.
  - Pointer increments after each data byte; 0xFF wraps to 0x00.
- RD_DATA: on each SCL fall (+HOLD_CYC), set sda_oe_out = ~bit, MSB first.
  - Data comes from reg[ptr] for ptr 0x00 and above up to 0x7F; ptr 0x80 and above reads 0x00.
  - Release SDA after bit 0, then enter RD_ACK.
- RD_ACK: sample on SCL rise.
  - ACK (0): pointer+1 (wrap), back to RD_DATA.
  - NACK (1): go to IGNORE and drop busy_out.
- Repeated START after PTR_ACK (write-then-read) keeps the pointer. This is the required combined-format read.
- Reset mid-transaction: SDA is released immediately (async), and the bus is re-acquired only at the next START.

Decomposition:
- mpr121_pkg holds:
  - the state_t enum;
  - register address constants (TOUCH_L 0x00, TOUCH_H 0x01, CDC_CFG 0x5C, CDT_CFG 0x5D, ECR 0x5E, SRST 0x80);
  - the soft-reset key 0x63;
  - register reset values.
- Sub-module i2c_line_sync: synchronizers plus scl_rise, scl_fall, start, stop pulses. Inputs are clk_in, rst_in, scl_in, sda_in and the sda_oe mask.

Test Plan:
- Write 0x5A/W, ptr 0x5E, data 0x0C -> three ACKs; ecr_out = 0x0C; one reg_wr pulse with addr 0x5E, data 0x0C.
- Then write ptr 0x41 data 0x0F with ECR = 0x0C -> ACKed, reg_wr_valid_out stays 0, and a readback of 0x41 returns 0x00.
- touch_in = 12'hA5C; write ptr 0x00, repeated START, 0x5A/R, read 2 bytes (ACK, NACK) -> 0x5C, 0x0A. Change touch_in mid-read -> the second byte is still 0x0A.
- Address 0x5B transaction -> sda_oe_out never asserted, busy_out = 0. A following 0x5A read of ptr 0x5D -> 0x24.
- Write ptr 0xFF, then write 2 bytes -> the pointer wraps to 0x00 and 0x01 (ignored). Write ptr 0x80 with data 0x63 -> ECR returns to 0x00 and reg 0x5D = 0x24.
- Assert rst_in low while driving an ACK -> sda_oe_out = 0 within the same cycle. The next full 0x5A transaction succeeds.
